// File: rtl/dtube_scan_pkg.sv
// Shared encodings and off-level helpers for the digit-tube scan driver.
package dtube_scan_pkg;

  localparam int DTUBE_NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    DSCAN_IDLE  = 2'd0,
    DSCAN_BLANK = 2'd1,
    DSCAN_DRIVE = 2'd2
  } dscan_state_t;

  // Segment bus level that leaves every segment dark
  function automatic logic [7:0] seg_off(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

  // Digit-enable level that leaves every digit dark
  function automatic logic [DTUBE_NUM_DIGITS-1:0] dig_off(input bit active_low);
    return active_low ? {DTUBE_NUM_DIGITS{1'b1}} : {DTUBE_NUM_DIGITS{1'b0}};
  endfunction

endpackage

// File: rtl/dtube_scan_timer.sv
// Slot cycle counter: counts from 0 until cleared, and flags the last
// cycle of the blank phase and of the drive phase.
module dtube_scan_timer #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic blank_tc,
  output logic drive_tc
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SLOT_CYCLES - BLANK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Free-running phase counter, restarted by the state machine at each phase boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign blank_tc = (cnt == BLANK_LAST);
  assign drive_tc = (cnt == DRIVE_LAST);

endmodule

// File: rtl/dtube_scan.sv
// Time-multiplexed six-digit tube scanner: blanks, then drives one digit per
// slot from a per-slot snapshot of its segment pattern.
module dtube_scan
  import dtube_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = DTUBE_NUM_DIGITS,
  parameter int SLOT_CYCLES    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        scan_en,
  input  logic [7:0]                  hex0,
  input  logic [7:0]                  hex1,
  input  logic [7:0]                  hex2,
  input  logic [7:0]                  hex3,
  input  logic [7:0]                  hex4,
  input  logic [7:0]                  hex5,
  output logic [7:0]                  seg_out,
  output logic [DTUBE_NUM_DIGITS-1:0] dig_sel,
  output logic                        frame_done
);

  localparam int IDX_W = $clog2(DTUBE_NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DTUBE_NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF = seg_off(SEG_ACTIVE_LOW);
  localparam logic [DTUBE_NUM_DIGITS-1:0] DIG_OFF = dig_off(DIG_ACTIVE_LOW);

  if (NUM_DIGITS != DTUBE_NUM_DIGITS || BLANK_CYCLES < 1 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_params
    $error("dtube_scan: need NUM_DIGITS == 6 and 1 <= BLANK_CYCLES < SLOT_CYCLES");
  end

  dscan_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       snap;
  logic [7:0]       hex_sel;
  logic             clr;
  logic             blank_tc;
  logic             drive_tc;

  // Incoming pattern is active-low; flip it when the pads want active-high segments
  function automatic logic [7:0] seg_on(input logic [7:0] pat);
    return SEG_ACTIVE_LOW ? pat : ~pat;
  endfunction

  // One-hot enable for the selected digit at the pad polarity
  function automatic logic [DTUBE_NUM_DIGITS-1:0] dig_on(input logic [IDX_W-1:0] sel);
    logic [DTUBE_NUM_DIGITS-1:0] one;
    one = {{(DTUBE_NUM_DIGITS-1){1'b0}}, 1'b1} << sel;
    return DIG_ACTIVE_LOW ? ~one : one;
  endfunction

  dtube_scan_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .blank_tc(blank_tc),
    .drive_tc(drive_tc)
  );

  // Pick the pattern of the digit about to be driven
  always_comb begin
    hex_sel = hex0;
    case (idx)
      3'd0:    hex_sel = hex0;
      3'd1:    hex_sel = hex1;
      3'd2:    hex_sel = hex2;
      3'd3:    hex_sel = hex3;
      3'd4:    hex_sel = hex4;
      3'd5:    hex_sel = hex5;
      default: hex_sel = hex0;
    endcase
  end

  // Restart the phase counter whenever a phase ends or scanning is idle
  always_comb begin
    clr = 1'b1;
    case (state)
      DSCAN_BLANK: clr = blank_tc;
      DSCAN_DRIVE: clr = drive_tc;
      default:     clr = 1'b1;
    endcase
    if (!scan_en) clr = 1'b1;
  end

  // Scan state machine with registered segment, digit and frame outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DSCAN_IDLE;
      idx        <= '0;
      snap       <= 8'hFF;
      seg_out    <= SEG_OFF;
      dig_sel    <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!scan_en) begin
        state   <= DSCAN_IDLE;
        idx     <= '0;
        seg_out <= SEG_OFF;
        dig_sel <= DIG_OFF;
      end else begin
        case (state)
          DSCAN_IDLE: begin
            state   <= DSCAN_BLANK;
            idx     <= '0;
            seg_out <= SEG_OFF;
            dig_sel <= DIG_OFF;
          end
          DSCAN_BLANK: begin
            seg_out <= SEG_OFF;
            dig_sel <= DIG_OFF;
            if (blank_tc) begin
              snap    <= hex_sel;
              seg_out <= seg_on(hex_sel);
              dig_sel <= dig_on(idx);
              state   <= DSCAN_DRIVE;
            end
          end
          DSCAN_DRIVE: begin
            seg_out <= seg_on(snap);
            dig_sel <= dig_on(idx);
            if (drive_tc) begin
              seg_out <= SEG_OFF;
              dig_sel <= DIG_OFF;
              state   <= DSCAN_BLANK;
              if (idx == LAST_IDX) begin
                idx        <= '0;
                frame_done <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          default: begin
            state   <= DSCAN_IDLE;
            idx     <= '0;
            seg_out <= SEG_OFF;
            dig_sel <= DIG_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dtube_scan.sv
// Directed bench for dtube_scan with 8-cycle slots and 2-cycle blanking.
module tb_dtube_scan;

  logic       clk;
  logic       rst_n;
  logic       scan_en;
  logic       scan_en2;
  logic [7:0] hex_m [6];
  logic [7:0] hexb_m [6];
  logic [7:0] seg_out, seg_out2;
  logic [5:0] dig_sel, dig_sel2;
  logic       frame_done, frame_done2;

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [7:0] snap_m = 8'hFF;

  dtube_scan #(
    .SLOT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
    .hex0(hex_m[0]), .hex1(hex_m[1]), .hex2(hex_m[2]),
    .hex3(hex_m[3]), .hex4(hex_m[4]), .hex5(hex_m[5]),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  dtube_scan #(
    .SLOT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en2),
    .hex0(hexb_m[0]), .hex1(hexb_m[1]), .hex2(hexb_m[2]),
    .hex3(hexb_m[3]), .hex4(hexb_m[4]), .hex5(hexb_m[5]),
    .seg_out(seg_out2), .dig_sel(dig_sel2), .frame_done(frame_done2)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when it disagrees
  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Expect the dark display for n cycles
  task automatic check_off(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_output("off seg", 32'(seg_out), 32'h FF);
      check_output("off dig", 32'(dig_sel), 32'h3F);
      check_output("off frame_done", 32'(frame_done), 32'h0);
    end
  endtask

  // Step n cycles of enabled scanning, checking against a slot/frame model
  // where k counts cycles since scan_en was raised from idle
  task automatic run_scan(input int n);
    int p, d;
    logic [7:0] exp_seg;
    logic [5:0] exp_dig;
    logic       exp_fd;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      p = (k - 1) % 8;
      d = ((k - 1) / 8) % 6;
      if (p == 2) snap_m = hex_m[d];
      exp_seg = (p < 2) ? 8'hFF : snap_m;
      exp_dig = (p < 2) ? 6'h3F : ~(6'b000001 << d);
      exp_fd  = (k > 1) && ((k - 1) % 48 == 0);
      check_output($sformatf("seg k=%0d", k), 32'(seg_out), 32'(exp_seg));
      check_output($sformatf("dig k=%0d", k), 32'(dig_sel), 32'(exp_dig));
      check_output($sformatf("frame_done k=%0d", k), 32'(frame_done), 32'(exp_fd));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    scan_en = 1'b0;
    scan_en2 = 1'b0;
    hex_m[0] = 8'hC0; hex_m[1] = 8'hF9; hex_m[2] = 8'hA4;
    hex_m[3] = 8'hB0; hex_m[4] = 8'h99; hex_m[5] = 8'h92;
    hexb_m[0] = 8'hC0; hexb_m[1] = 8'hF9; hexb_m[2] = 8'hA4;
    hexb_m[3] = 8'hB0; hexb_m[4] = 8'h99; hexb_m[5] = 8'h92;

    repeat (2) @(negedge clk);
    check_output("reset seg", 32'(seg_out), 32'hFF);
    check_output("reset dig", 32'(dig_sel), 32'h3F);
    check_output("reset frame_done", 32'(frame_done), 32'h0);
    check_output("reset hi seg", 32'(seg_out2), 32'h00);
    check_output("reset hi dig", 32'(dig_sel2), 32'h00);
    rst_n = 1'b1;

    // Disabled after reset
    check_off(20);

    // Two full frames and into the third
    scan_en = 1'b1;
    k = 0;
    run_scan(116);

    // Mid-drive change of digit 2 must not tear the current slot
    hex_m[2] = 8'h80;
    run_scan(62);

    // Change landing exactly on digit 4's capture edge is taken
    hex_m[4] = 8'h88;
    run_scan(42);

    // Drop scan_en during digit 3 drive, then restart from digit 0
    scan_en = 1'b0;
    check_off(3);
    scan_en = 1'b1;
    k = 0;
    run_scan(37);

    // Asynchronous reset in the middle of digit 4 drive
    #2 rst_n = 1'b0;
    #1;
    check_output("async rst seg", 32'(seg_out), 32'hFF);
    check_output("async rst dig", 32'(dig_sel), 32'h3F);
    check_output("async rst frame_done", 32'(frame_done), 32'h0);
    check_off(2);
    rst_n = 1'b1;
    k = 0;
    run_scan(24);

    // Active-high build: dark levels 00, digit 0 shows ~C0 on enable bit 0
    scan_en2 = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check_output("hi blank seg", 32'(seg_out2), 32'h00);
        check_output("hi blank dig", 32'(dig_sel2), 32'h00);
      end
      if (i == 3) begin
        check_output("hi d0 seg", 32'(seg_out2), 32'h3F);
        check_output("hi d0 dig", 32'(dig_sel2), 32'h01);
      end
      if (i == 11) begin
        check_output("hi d1 seg", 32'(seg_out2), 32'h06);
        check_output("hi d1 dig", 32'(dig_sel2), 32'h02);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
